// File: rtl/spi_pwm_config_ctrl_if.sv
// SPI pad bundle between an off-chip controller and spi_pwm_config_ctrl.
// The cipo line exists only when SPI_READBACK_EN is defined.
interface spi_pwm_config_ctrl_if;
  logic sclk;
  logic copi;
  logic ncs;
`ifdef SPI_READBACK_EN
  logic cipo;

  modport master (output sclk, output copi, output ncs, input cipo);
  modport slave  (input sclk, input copi, input ncs, output cipo);
`else
  modport master (output sclk, output copi, output ncs);
  modport slave  (input sclk, input copi, input ncs);
`endif
endinterface

// File: rtl/spi_pwm_config_ctrl.sv
// SPI slave holding the five 8-bit PWM configuration registers (16-bit write frames, mode 0).
// Optional register readback on cipo is built when SPI_READBACK_EN is defined.
module spi_pwm_config_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_pwm_config_ctrl_if.slave       spi,
  output logic [7:0]                 en_reg_out_7_0,
  output logic [7:0]                 en_reg_out_15_8,
  output logic [7:0]                 en_reg_pwm_7_0,
  output logic [7:0]                 en_reg_pwm_15_8,
  output logic [7:0]                 pwm_duty_cycle
);

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned NUM_REGS   = 5;

  localparam logic [CNT_W-1:0]  CNT_FRAME = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_BITS + 1);
  // Registers beyond the five physical ones are never mapped, whatever MAX_ADDR says.
  localparam logic [ADDR_W-1:0] LAST_ADDR = (MAX_ADDR < NUM_REGS) ? ADDR_W'(MAX_ADDR)
                                                                  : ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic                   sclk_hist_q;
  logic                   ncs_hist_q;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  state_e                  state_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [FRAME_BITS-1:0]   shift_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_W-1:0]       regs_q [NUM_REGS];
  logic                    commit_ok;

  // Pad synchronizers plus one history flop for edge detection. The ncs chain
  // resets low so a chip select already asserted at reset is not seen as a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '0;
      sclk_hist_q <= 1'b0;
      ncs_hist_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0],  spi.ncs};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      ncs_hist_q  <= ncs_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    copi_s    = copi_sync_q[SYNC_STAGES-1];
    ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_hist_q;
    sclk_fall = ~sclk_s & sclk_hist_q;
    ncs_rise  = ncs_s & ~ncs_hist_q;
    ncs_fall  = ~ncs_s & ncs_hist_q;
    shift_d   = {shift_q[FRAME_BITS-2:0], copi_s};
    commit_ok = (cnt_q == CNT_FRAME) && shift_q[15] && (shift_q[14:8] <= LAST_ADDR);
  end

  // Frame FSM; the target register is written on the edge that leaves COMMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            state_q <= SHIFT;
            shift_q <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state_q <= COMMIT;
          end else if (sclk_rise && !ncs_s) begin
            shift_q <= shift_d;
            if (cnt_q != CNT_SAT) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        COMMIT: begin
          if (commit_ok) begin
            regs_q[shift_q[10:8]] <= shift_q[7:0];
          end
          if (ncs_fall) begin
            state_q <= SHIFT;
            shift_q <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_HDR = CNT_W'(8);

  logic [DATA_W-1:0] out_q;
  logic              rd_active_q;
  logic              cipo_q;
  logic [DATA_W-1:0] rd_val;

  // After 8 bits the low byte of the shifter is {R/W, address}.
  always_comb begin
    rd_val = '0;
    if (shift_q[6:0] <= LAST_ADDR) begin
      rd_val = regs_q[shift_q[2:0]];
    end
  end

  // Load on the falling edge after the header so the MSB is valid for the 9th rising edge.
  always_ff @(posedge clk) begin
    if (rst || (state_q != SHIFT) || ncs_s) begin
      out_q       <= '0;
      rd_active_q <= 1'b0;
      cipo_q      <= 1'b0;
    end else if (sclk_fall) begin
      if (!rd_active_q && (cnt_q == CNT_HDR) && !shift_q[7]) begin
        out_q       <= rd_val;
        rd_active_q <= 1'b1;
        cipo_q      <= rd_val[7];
      end else if (rd_active_q) begin
        out_q  <= {out_q[DATA_W-2:0], 1'b0};
        cipo_q <= out_q[DATA_W-2];
      end
    end
  end

  assign spi.cipo = cipo_q;
`endif

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_spi_pwm_config_ctrl.sv
// Bench for spi_pwm_config_ctrl: table of frames with expected register images via a
// scoreboard queue, plus sequences for latency, mid-frame reset and SPI_READBACK_EN reads.
module tb_spi_pwm_config_ctrl;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned HALF        = 8;
  localparam int unsigned NVEC        = 10;

  logic       clk;
  logic       rst;
  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;

  spi_pwm_config_ctrl_if spi_bus ();

  spi_pwm_config_ctrl #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .spi             (spi_bus),
    .en_reg_out_7_0  (out_lo),
    .en_reg_out_15_8 (out_hi),
    .en_reg_pwm_7_0  (pwm_lo),
    .en_reg_pwm_15_8 (pwm_hi),
    .pwm_duty_cycle  (duty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] word;
    int          nbits;
    logic [39:0] exp;   // {out_7_0, out_15_8, pwm_7_0, pwm_15_8, duty}
  } vec_t;

  vec_t        vecs [NVEC];
  logic [39:0] sb_q [$];
  int          n_checks;
  int          n_pass;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
  endtask

  task automatic check_regs(input string name, input logic [39:0] exp);
    check8({name, " out_7_0"},  out_lo, exp[39:32]);
    check8({name, " out_15_8"}, out_hi, exp[31:24]);
    check8({name, " pwm_7_0"},  pwm_lo, exp[23:16]);
    check8({name, " pwm_15_8"}, pwm_hi, exp[15:8]);
    check8({name, " duty"},     duty,   exp[7:0]);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI bit, mode 0; cipo is sampled just before the rising edge.
  task automatic spi_bit(input logic b, output logic c);
    spi_bus.copi = b;
    wait_clks(HALF);
`ifdef SPI_READBACK_EN
    c = spi_bus.cipo;
`else
    c = 1'b0;
`endif
    spi_bus.sclk = 1'b1;
    wait_clks(HALF);
    spi_bus.sclk = 1'b0;
  endtask

  // Lowers ncs and clocks nbits bits (zeros past bit 16); leaves ncs low.
  task automatic spi_shift(input logic [15:0] word, input int nbits, output logic [7:0] rdata);
    logic c;
    rdata = '0;
    spi_bus.ncs = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_bit((i < 16) ? word[15-i] : 1'b0, c);
      if (i >= 8 && i < 16) rdata[15-i] = c;
    end
    wait_clks(HALF);
  endtask

  task automatic spi_frame(input logic [15:0] word, input int nbits, output logic [7:0] rdata);
    spi_shift(word, nbits, rdata);
    spi_bus.ncs = 1'b1;
    wait_clks(12);
  endtask

  initial begin
    logic [7:0]  rdata;
    logic [39:0] exp;
    int          cycles;
    logic        c;

    n_checks = 0;
    n_pass   = 0;

    vecs[0] = '{"wr 00<-F0",       16'h80F0, 16, 40'hF0_00_00_00_00};
    vecs[1] = '{"wr 04<-80",       16'h8480, 16, 40'hF0_00_00_00_80};
    vecs[2] = '{"wr 02<-01",       16'h8201, 16, 40'hF0_00_01_00_80};
    vecs[3] = '{"short 15b 01",    16'h813C, 15, 40'hF0_00_01_00_80};
    vecs[4] = '{"long 17b 01",     16'h813C, 17, 40'hF0_00_01_00_80};
    vecs[5] = '{"unmapped 05",     16'h85AA, 16, 40'hF0_00_01_00_80};
    vecs[6] = '{"unmapped 7F",     16'hFF55, 16, 40'hF0_00_01_00_80};
    vecs[7] = '{"read 00 no wr",   16'h0077, 16, 40'hF0_00_01_00_80};
    vecs[8] = '{"wr 01<-5A",       16'h815A, 16, 40'hF0_5A_01_00_80};
    vecs[9] = '{"overwrite 00<-0F",16'h800F, 16, 40'h0F_5A_01_00_80};

    rst          = 1'b1;
    spi_bus.sclk = 1'b0;
    spi_bus.copi = 1'b0;
    spi_bus.ncs  = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(5);
    check_regs("reset", 40'h0);

    for (int v = 0; v < int'(NVEC); v++) begin
      sb_q.push_back(vecs[v].exp);
      spi_frame(vecs[v].word, vecs[v].nbits, rdata);
      exp = sb_q.pop_front();
      check_regs(vecs[v].name, exp);
    end

    // ncs rise to register update latency
    spi_shift(16'h8322, 16, rdata);
    spi_bus.ncs = 1'b1;
    cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (pwm_hi == 8'h22) break;
    end
    check8("latency cycles", 8'(cycles), 8'(SYNC_STAGES + 2));
    check8("latency value", pwm_hi, 8'h22);
    wait_clks(12);

    // Reset after 10 bits of 03<-FF aborts the frame; ncs stays low across reset.
    spi_bus.ncs = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 10; i++) spi_bit(16'h83FF >> (15 - i), c);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(2);
    check_regs("mid-frame rst", 40'h0);
    for (int i = 10; i < 16; i++) spi_bit(16'h83FF >> (15 - i), c);
    wait_clks(HALF);
    spi_bus.ncs = 1'b1;
    wait_clks(12);
    check_regs("aborted tail", 40'h0);
    spi_frame(16'h830F, 16, rdata);
    check_regs("post-rst wr 03<-0F", 40'h00_00_00_0F_00);

`ifdef SPI_READBACK_EN
    spi_frame(16'h84C3, 16, rdata);
    check8("rb wr duty", duty, 8'hC3);
    spi_frame(16'h0400, 16, rdata);
    check8("rb read 04", rdata, 8'hC3);
    check8("rb read keeps duty", duty, 8'hC3);
    spi_frame(16'h0600, 16, rdata);
    check8("rb read 06", rdata, 8'h00);
    check8("rb idle cipo", {7'd0, spi_bus.cipo}, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
